// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds the FAULT state).
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    FAULT
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: sequential step or PC-relative target.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (flags unaligned targets
// instead of silently clearing the low address bits).
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] ImmExt,
  input  logic                  PCSrc,
  output logic [ADDR_WIDTH-1:0] pc_next,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                  misalign,
`endif
  output logic [ADDR_WIDTH-1:0] pc_plus4
);

  logic [ADDR_WIDTH-1:0] target;

  assign pc_plus4 = pc + ADDR_WIDTH'(PC_STEP);

  // Select the raw target; additions wrap modulo 2^ADDR_WIDTH.
  always_comb begin
    target = PCSrc ? (pc + ImmExt) : pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    pc_next  = target;
    misalign = |target[1:0];
`else
    pc_next  = target & ~ADDR_WIDTH'(3);
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/gnt/rvalid
// handshake and presents one registered instruction at a time.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misalign_o port, FAULT state).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   PCSrc_i,
  input  logic [ADDR_WIDTH-1:0]  ImmExt_i,
  input  logic                   stall_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                   misalign_o,
`endif
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o
);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_next;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   pc_load, instr_load;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                   next_misalign;
`endif

  fetch_pc_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_next (
    .pc       (pc_q),
    .ImmExt   (ImmExt_i),
    .PCSrc    (PCSrc_i),
    .pc_next  (pc_next),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign (next_misalign),
`endif
    .pc_plus4 (pc_plus4_o)
  );

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;

  // Next-state and Moore outputs; rvalid outside WAIT is dropped.
  always_comb begin
    state_d       = state_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    instr_load    = 1'b0;
    pc_load       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_o    = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          instr_load = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
        instr_valid_o = 1'b1;
        if (!stall_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_misalign) begin
            state_d = FAULT;
          end else begin
            pc_load = 1'b1;
            state_d = REQ;
          end
`else
          pc_load = 1'b1;
          state_d = REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: misalign_o = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // PC register, advanced only when the presented instruction is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      pc_q <= RESET_PC;
    else if (pc_load) pc_q <= pc_next;
  end

  // Instruction register, loaded from the memory response in WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         instr_q <= '0;
    else if (instr_load) instr_q <= imem_rdata_i;
  end

endmodule
